// File: rtl/lpc_kq_sequencer.sv
// Feeds one LPC frame of raw k values through the shared quantizer and writes the
// quantized k/b pairs into the coefficient store. Optional build macro: LPC_STAB_CHECK_EN.
module lpc_kq_sequencer #(
  parameter int MAX_ORDER = 10,
  parameter int AW        = 4,
  parameter int Q_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] order,
  input  logic [31:0]   kin,
  input  logic          kin_valid,
  output logic          kin_ready,
  output logic [31:0]   q_k_tmp,
  output logic          q_v,
  input  logic [15:0]   q_k,
  input  logic [15:0]   q_b,
  input  logic          q_vout,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_k,
  output logic [15:0]   wr_b,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_IN = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_STORE   = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;

  localparam int         TW        = $clog2(Q_TIMEOUT) + 1;
  localparam logic [AW:0] MAX_ORD  = (AW+1)'(MAX_ORDER);

  // kin is accepted on kin_valid & kin_ready; kin_ready is high only in WAIT_IN,
  // and q_v stays high through ISSUE so the quantizer sees a stable q_k_tmp.
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] order_q, order_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   k_tmp_q, k_tmp_d;
  logic [15:0]   wk_q, wk_d;
  logic [15:0]   wb_q, wb_d;
  logic          err_q, err_d;
  logic          order_ok;
  logic          bad_start;

  assign order_ok  = (order != '0) && ({1'b0, order} <= MAX_ORD);
  assign bad_start = (state_q == S_IDLE) && start && !order_ok;

`ifdef LPC_STAB_CHECK_EN
  logic [15:0] wk_mag;
  assign wk_mag = wk_q[15] ? (~wk_q + 16'd1) : wk_q;
`endif

  always_comb begin
    state_d = state_q;
    order_d = order_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    k_tmp_d = k_tmp_q;
    wk_d    = wk_q;
    wb_d    = wb_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (order_ok) begin
            order_d = order;
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = S_WAIT_IN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT_IN: begin
        if (kin_valid) begin
          k_tmp_d = kin;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (q_vout) begin
          wk_d    = q_k;
          wb_d    = q_b;
          state_d = S_STORE;
        end else if (tmo_q == TW'(Q_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_STORE: begin
`ifdef LPC_STAB_CHECK_EN
        // |k| close to 1 means an unstable lattice: keep this write, drop the rest
        if (wk_mag >= 16'h7FF0) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else
`endif
        if (idx_q == order_q - AW'(1)) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_WAIT_IN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      order_q <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      k_tmp_q <= '0;
      wk_q    <= '0;
      wb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      k_tmp_q <= k_tmp_d;
      wk_q    <= wk_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  assign kin_ready = (state_q == S_WAIT_IN);
  assign q_v       = (state_q == S_ISSUE);
  assign q_k_tmp   = k_tmp_q;
  assign wr_en     = (state_q == S_STORE);
  assign wr_addr   = idx_q;
  assign wr_k      = wk_q;
  assign wr_b      = wb_q;
  assign busy      = (state_q != S_IDLE);
  // A rejected start reports its done in the same cycle.
  assign done      = (state_q == S_FIN) || bad_start;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
